vd7_fsm: RTL and testbench



---
 rtl/vd7_pkg.sv | 18 +
 rtl/vd7_fsm_sva.sv | 44 ++++
 rtl/vd7_fsm.sv | 39 +++
 tb/tb_vd7_fsm.sv | 129 ++++++++++++
 4 files changed

// File: rtl/vd7_pkg.sv
// vd7 sequence detector shared types.
// State encoding and reset state constant.
package vd7_pkg;

  typedef enum logic [1:0] {
    A = 2'b00,
    B = 2'b01,
    C = 2'b10,
    F = 2'b11
  } vd7_state_t;

  localparam vd7_state_t VD7_RESET_STATE = A;

  function automatic logic vd7_q(input vd7_state_t s);
    return (s == C) || (s == F);
  endfunction

endpackage

// File: rtl/vd7_fsm_sva.sv
// vd7 FSM assertions, attached by bind.
// Reset, each transition, and output decode.
module vd7_fsm_sva
  import vd7_pkg::*;
(
  input logic       clk,
  input logic       Reset,
  input logic       w,
  input vd7_state_t state,
  input logic       q
);

  a_reset: assert property (@(posedge clk)
    Reset |=> state == A);

  a_a0: assert property (@(posedge clk)
    !Reset && state == A && !w |=> state == B);
  a_a1: assert property (@(posedge clk)
    !Reset && state == A && w |=> state == F);
  a_b0: assert property (@(posedge clk)
    !Reset && state == B && !w |=> state == C);
  a_b1: assert property (@(posedge clk)
    !Reset && state == B && w |=> state == F);
  a_c0: assert property (@(posedge clk)
    !Reset && state == C && !w |=> state == C);
  a_c1: assert property (@(posedge clk)
    !Reset && state == C && w |=> state == F);
  a_f0: assert property (@(posedge clk)
    !Reset && state == F && !w |=> state == B);
  a_f1: assert property (@(posedge clk)
    !Reset && state == F && w |=> state == F);

  a_q: assert property (@(posedge clk)
    q == (state == C || state == F));

endmodule

bind vd7_fsm vd7_fsm_sva u_vd7_fsm_sva (
  .clk   (clk),
  .Reset (Reset),
  .w     (w),
  .state (state),
  .q     (q)
);

// File: rtl/vd7_fsm.sv
// vd7 Moore detector: q high after 2+ zeros
// or after a one on w.
module vd7_fsm
  import vd7_pkg::*;
(
  input  logic clk,
  input  logic Reset,
  input  logic w,
  output logic q
);

  vd7_state_t state;
  vd7_state_t state_nxt;

  // State register, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (Reset) state <= VD7_RESET_STATE;
    else       state <= state_nxt;
  end

  // Next-state: a one always goes to F, zeros count up to C.
  always_comb begin
    state_nxt = A;
    case (state)
      A:       state_nxt = w ? F : B;
      B:       state_nxt = w ? F : C;
      C:       state_nxt = w ? F : C;
      F:       state_nxt = w ? F : B;
      default: state_nxt = A;
    endcase
  end

  // Moore output decode from the state register only.
  always_comb begin
    q = 1'b0;
    q = vd7_q(state);
  end

endmodule

// File: tb/tb_vd7_fsm.sv
// vd7_fsm bench: directed plus random stimulus,
// scoreboard against a run-length reference model.
module tb_vd7_fsm;

  logic clk = 1'b0;
  logic Reset = 1'b0;
  logic w = 1'b0;
  logic q;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0] st;
    logic       q;
    string      tag;
  } exp_t;

  exp_t sb[$];

  bit have_hist = 0;
  int zeros = 0;
  bit last_one = 0;

  vd7_fsm dut (
    .clk   (clk),
    .Reset (Reset),
    .w     (w),
    .q     (q)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] model_state();
    if (!have_hist) return 2'b00;
    if (last_one) return 2'b11;
    if (zeros == 1) return 2'b01;
    return 2'b10;
  endfunction

  task automatic step(input bit r, input bit wi, input string tag);
    exp_t e;
    @(negedge clk);
    Reset = r;
    w = wi;
    if (r) begin
      have_hist = 0;
      zeros = 0;
      last_one = 0;
    end else if (wi) begin
      have_hist = 1;
      zeros = 0;
      last_one = 1;
    end else begin
      have_hist = 1;
      zeros = zeros + 1;
      last_one = 0;
    end
    e.st = model_state();
    e.q = last_one || (zeros >= 2);
    e.tag = tag;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    logic [1:0] ds;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        ds = dut.state;
        tests++;
        if (ds !== e.st) begin
          fails++;
          $display("FAIL %s state: got %b want %b", e.tag, ds, e.st);
        end
        tests++;
        if (q !== e.q) begin
          fails++;
          $display("FAIL %s q: got %b want %b", e.tag, q, e.q);
        end
      end
    end
  end

  initial begin : driver
    bit r;
    int wait_cyc;
    for (int i = 0; i < 12; i++) step(1'b1, i[0], "reset_hold");
    step(1'b0, 1'b0, "zero_run");
    step(1'b0, 1'b0, "zero_run");
    step(1'b0, 1'b0, "zero_run");
    step(1'b0, 1'b0, "zero_run");
    step(1'b0, 1'b1, "mixed");
    step(1'b0, 1'b1, "mixed");
    step(1'b0, 1'b0, "mixed");
    step(1'b0, 1'b1, "mixed");
    step(1'b0, 1'b0, "mixed");
    step(1'b1, 1'b0, "idle_reset");
    step(1'b0, 1'b1, "idle_one");
    step(1'b0, 1'b0, "idle_one");
    step(1'b0, 1'b1, "idle_one");
    step(1'b0, 1'b0, "to_c");
    step(1'b0, 1'b0, "to_c");
    step(1'b1, 1'b1, "mid_reset");
    step(1'b0, 1'b0, "after_reset");
    step(1'b0, 1'b0, "after_reset2");
    for (int i = 0; i < 10000; i++) begin
      r = ($urandom_range(0, 39) == 0);
      step(r, 1'(($urandom() >> 3) & 1), "random");
    end
    wait_cyc = 0;
    while (sb.size() != 0 && wait_cyc < 10) begin
      @(posedge clk);
      #2;
      wait_cyc++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d left want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
